// File: rtl/truth_table_capture_if.sv
// Bundle between the truth-table sweeper and its test harness: control, the
// device-under-test response, and the captured/compared results.
interface truth_table_capture_if;
  logic       start;
  logic       abort;
  logic       m;
  logic [7:0] exp_table;
  logic [2:0] a;
  logic       busy;
  logic       done;
  logic [7:0] table_q;
  logic       pass;
  logic [2:0] mismatch_idx;

  modport master (
    output start, abort, m, exp_table,
    input  a, busy, done, table_q, pass, mismatch_idx
  );

  modport slave (
    input  start, abort, m, exp_table,
    output a, busy, done, table_q, pass, mismatch_idx
  );
endinterface

// File: rtl/truth_table_capture.sv
// Steps a 3-input combinational block through all 8 vectors, holding each for
// DWELL cycles and capturing its response. Optional TT_COMPARE_EN adds pass/mismatch.
module truth_table_capture #(
  parameter int unsigned DWELL = 25
) (
  input  logic                      clk,
  input  logic                      rst_n,
  truth_table_capture_if.slave      bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_q;
  logic [7:0] cnt_q;
  logic [2:0] a_q;
  logic       busy_q;
  logic       done_q;
  logic [7:0] cap_q;
  logic       pass_q;
  logic [2:0] mismatch_q;

  logic [7:0] cap_d;
  logic       pass_d;
  logic [2:0] mismatch_d;

  // Lowest set bit of a difference vector; zero when nothing differs.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Captured table as it will look once the current vector's response is stored.
  always_comb begin
    cap_d       = cap_q;
    cap_d[a_q]  = bus.m;
  end

`ifdef TT_COMPARE_EN
  // Verdict on the completed table, latched on the final sample edge.
  always_comb begin
    pass_d     = (cap_d == bus.exp_table);
    mismatch_d = lowest_set(cap_d ^ bus.exp_table);
  end
`else
  // Comparison disabled: verdict outputs are tied low.
  always_comb begin
    pass_d     = 1'b0;
    mismatch_d = 3'd0;
  end
`endif

  // Sweep controller; every output comes straight from a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      a_q        <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cap_q      <= 8'd0;
      pass_q     <= 1'b0;
      mismatch_q <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          // Abort is meaningless here; start alone decides.
          if (bus.start) begin
            state_q    <= S_DRIVE;
            busy_q     <= 1'b1;
            a_q        <= 3'd0;
            cnt_q      <= 8'd0;
            cap_q      <= 8'd0;
            pass_q     <= 1'b0;
            mismatch_q <= 3'd0;
          end
        end
        S_DRIVE: begin
          if (bus.abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            a_q     <= 3'd0;
            cnt_q   <= 8'd0;
            cap_q   <= 8'd0;
          end else if (cnt_q == DWELL_LAST) begin
            cnt_q <= 8'd0;
            cap_q <= cap_d;
            if (a_q == 3'd7) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              pass_q     <= pass_d;
              mismatch_q <= mismatch_d;
            end else begin
              a_q <= a_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          a_q     <= 3'd0;
          cnt_q   <= 8'd0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          a_q     <= 3'd0;
          cnt_q   <= 8'd0;
        end
      endcase
    end
  end

  assign bus.a            = a_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.table_q      = cap_q;
  assign bus.pass         = pass_q;
  assign bus.mismatch_idx = mismatch_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Randomized bench for truth_table_capture: a sweep-level reference model is
// compared against every output each cycle, plus literal checks of key results.
module tb_truth_table_capture;
  localparam int D  = 25;
  localparam int SW = 8 * D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_table_capture_if bus ();
  truth_table_capture_if bus2 ();

  truth_table_capture #(.DWELL(D)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  truth_table_capture #(.DWELL(2)) u_fast (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int total = 0;
  int bad   = 0;
  int ecount = 0;
  int t0;
  int t2;

  logic       m_act;
  int         m_el;
  logic [7:0] m_tbl;
  logic       m_pss;
  logic [2:0] m_mis;
  logic [7:0] gate_tt;
  logic       noise;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [2:0] low_diff(input logic [7:0] x, input logic [7:0] y);
    for (int i = 0; i < 8; i++) begin
      if (x[i] != y[i]) return 3'(i);
    end
    return 3'd0;
  endfunction

  function automatic logic [7:0] with_bit(input logic [7:0] t, input int i, input logic v);
    logic [7:0] r;
    r = t;
    r[i] = v;
    return r;
  endfunction

  function automatic logic [31:0] outs();
    return {15'd0, bus.a, bus.busy, bus.done, bus.table_q, bus.pass, bus.mismatch_idx};
  endfunction

  function automatic logic [31:0] expected();
    logic [2:0] a_e;
    if (!m_act) a_e = 3'd0;
    else if (m_el >= SW) a_e = 3'd7;
    else a_e = 3'(m_el / D);
    return {15'd0, a_e, m_act, (m_act && m_el == SW), m_tbl, m_pss, m_mis};
  endfunction

  // The gate emulated for the main DUT only settles in the last cycle of each dwell.
  assign bus.m   = (m_act && m_el < SW && (m_el % D) == D - 1) ? gate_tt[bus.a] : noise;
  assign bus2.m  = ^bus2.a;

  always @(posedge clk) ecount <= ecount + 1;
  always @(negedge clk) noise <= 1'($urandom);

  // Reference model: elapsed edges since the accepted start decide everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0; m_el <= 0; m_tbl <= 8'd0; m_pss <= 1'b0; m_mis <= 3'd0;
    end else if (!m_act) begin
      if (bus.start) begin
        m_act <= 1'b1; m_el <= 0; m_tbl <= 8'd0; m_pss <= 1'b0; m_mis <= 3'd0;
      end
    end else if (m_el == SW) begin
      m_act <= 1'b0;
    end else if (bus.abort) begin
      m_act <= 1'b0; m_tbl <= 8'd0;
    end else begin
      m_el <= m_el + 1;
      if ((m_el + 1) % D == 0) begin
        m_tbl <= with_bit(m_tbl, (m_el + 1) / D - 1, gate_tt[(m_el + 1) / D - 1]);
`ifdef TT_COMPARE_EN
        if (m_el + 1 == SW) begin
          m_pss <= (with_bit(m_tbl, 7, gate_tt[7]) == bus.exp_table);
          m_mis <= low_diff(with_bit(m_tbl, 7, gate_tt[7]), bus.exp_table);
        end
`endif
      end
    end
  end

  always @(negedge clk) chk("cycle", outs(), expected());

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!bus.done && n < SW + 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(ecount - t0), 32'(SW));
  endtask

  task automatic begin_sweep();
    bus.start = 1'b1;
    t0 = ecount + 1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.exp_table = 8'hE8; gate_tt = 8'hE8;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.exp_table = 8'h96;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs(), 32'd0);

    // Start offered together with reset release: must be taken on the first edge.
    rst_n = 1'b1;
    begin_sweep();
    wait_done("lat_majority");
    chk("tbl_majority", 32'(bus.table_q), 32'h0000_00E8);
`ifdef TT_COMPARE_EN
    chk("pass_match", 32'(bus.pass), 32'd1);
`else
    chk("pass_match", 32'(bus.pass), 32'd0);
`endif
    chk("mis_match", 32'(bus.mismatch_idx), 32'd0);

    repeat (4) @(negedge clk);
    bus.exp_table = 8'hE9;
    begin_sweep();
    wait_done("lat_e9");
    chk("pass_e9", 32'(bus.pass), 32'd0);
    chk("mis_e9", 32'(bus.mismatch_idx), 32'd0);

    repeat (3) @(negedge clk);
    bus.exp_table = 8'hE8;
    begin_sweep();
    repeat (49) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("lat_restart");
    chk("tbl_restart", 32'(bus.table_q), 32'h0000_00E8);
    repeat (30) @(negedge clk);
    chk("tbl_hold", 32'(bus.table_q), 32'h0000_00E8);

    begin_sweep();
    repeat (59) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_tbl", 32'(bus.table_q), 32'd0);
    repeat (SW + 10) @(negedge clk);
    begin_sweep();
    wait_done("lat_after_abort");

    for (int it = 0; it < 6; it++) begin
      int ab;
      repeat (3) @(negedge clk);
      gate_tt = 8'($urandom);
      bus.exp_table = ($urandom_range(0, 1) == 1) ? gate_tt : 8'($urandom);
      ab = (it % 2 == 0) ? int'($urandom_range(1, SW - 1)) : -1;
      bus.start = 1'b1;
      bus.abort = 1'($urandom_range(0, 1));
      @(negedge clk);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      for (int c = 1; c < SW + 4; c++) begin
        bus.start = (m_act && m_el < SW - 2 && $urandom_range(0, 29) == 0);
        bus.abort = (c == ab);
        @(negedge clk);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    gate_tt = 8'hE8;
    begin_sweep();
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", outs(), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (SW + 10) @(negedge clk);
    begin_sweep();
    wait_done("lat_after_reset");
    chk("tbl_after_reset", 32'(bus.table_q), 32'h0000_00E8);

    bus2.start = 1'b1;
    t2 = ecount + 1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int n = 0; n < 40 && !bus2.done; n++) @(negedge clk);
    chk("lat_fast", 32'(ecount - t2), 32'd16);
    chk("tbl_fast", 32'(bus2.table_q), 32'h0000_0096);
`ifdef TT_COMPARE_EN
    chk("pass_fast", 32'(bus2.pass), 32'd1);
`else
    chk("pass_fast", 32'(bus2.pass), 32'd0);
`endif

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
